// File: rtl/alu_seq.sv
// RV32I-style integer ALU with valid/ready on both sides; shifts run 1 bit per cycle.
// Define ALU_BARREL_SHIFT_EN to build a single-cycle barrel shifter instead (every op latency 1).
module alu_seq #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic            i_alt,
    input  logic [XLEN-1:0] i_input_a,
    input  logic [XLEN-1:0] i_input_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    // Handshake: a request transfers on a rising edge where i_valid & o_ready & ~i_flush;
    // a result transfers on a rising edge where o_valid & i_ready. o_ready never looks at i_valid.
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   alu_res;
    logic [SHW-1:0]    shamt;
    logic [3:0]        opc;
    logic              accept;
    logic              is_shift;

    assign opc      = {i_alt, i_op};
    assign shamt    = i_input_b[SHW-1:0];
    assign is_shift = (opc == 4'b0001) || (i_op == 3'b101);
    assign o_ready  = (state_q == IDLE) || ((state_q == DONE) && i_ready);
    assign accept   = i_valid && o_ready && !i_flush;
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;

    logic [XLEN-1:0] sll_r, srl_r, sra_r;
`ifdef ALU_BARREL_SHIFT_EN
    assign sll_r  = i_input_a << shamt;
    assign srl_r  = i_input_a >> shamt;
    assign sra_r  = XLEN'($signed(i_input_a) >>> shamt);
    assign o_busy = 1'b0;
`else
    // Single-cycle shift path only serves shamt==0; nonzero amounts go through SHIFT.
    assign sll_r  = i_input_a;
    assign srl_r  = i_input_a;
    assign sra_r  = i_input_a;
    assign o_busy = (state_q == SHIFT);

    logic [XLEN-1:0] sh_q, sh_d, sh_next;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            left_q, left_d, arith_q, arith_d;
    logic            start_iter;

    assign start_iter = is_shift && (shamt != '0);
    assign sh_next    = left_q ? {sh_q[XLEN-2:0], 1'b0}
                               : {arith_q & sh_q[XLEN-1], sh_q[XLEN-1:1]};
`endif

    always_comb begin
        alu_res = '0;
        case (opc)
            4'b0000: alu_res = i_input_a + i_input_b;
            4'b1000: alu_res = i_input_a - i_input_b;
            4'b0001: alu_res = sll_r;
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(i_input_a) < $signed(i_input_b)};
            4'b0011: alu_res = {{(XLEN-1){1'b0}}, i_input_a < i_input_b};
            4'b0100: alu_res = i_input_a ^ i_input_b;
            4'b0110: alu_res = i_input_a | i_input_b;
            4'b0111: alu_res = i_input_a & i_input_b;
            4'b0101: alu_res = srl_r;
            4'b1101: alu_res = sra_r;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifndef ALU_BARREL_SHIFT_EN
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
`endif
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if ((state_q == DONE) && i_ready) state_d = IDLE;
                    if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (start_iter) begin
                            sh_d    = i_input_a;
                            cnt_d   = shamt;
                            left_d  = (i_op == 3'b001);
                            arith_d = i_alt;
                            state_d = SHIFT;
                        end else
`endif
                        begin
                            result_d = alu_res;
                            state_d  = DONE;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        result_d = sh_next;
                        state_d  = DONE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
`ifndef ALU_BARREL_SHIFT_EN
            sh_q    <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
`ifndef ALU_BARREL_SHIFT_EN
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
`endif
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised successor to the single-cycle registered ALU. Covers the full RV32I integer op set, including SUB, SLL and SRA, with a valid/ready handshake on both input and output. Shifts run on an iterative 1-bit-per-cycle shifter. Sits between decode/operand-read and writeback in the multi-cycle core datapath.

Parameters:
XLEN, 32, operand/result width; must be a power of two, minimum 8
SHW, $clog2(XLEN), shift-amount width (derived; not overridden)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  operation request
o_ready  output  1  block can accept a request this cycle
i_op  input  3  funct3 encoding
i_alt  input  1  funct7[5] (SUB / SRA select)
i_input_a  input  XLEN  operand A
i_input_b  input  XLEN  operand B (shift amount = low SHW bits)
i_flush  input  1  synchronous abort
o_valid  output  1  result available
i_ready  input  1  consumer takes result
o_result  output  XLEN  result, registered
o_busy  output  1  high while in SHIFT

Behaviour:
- Reset (async, i_rst_n low): state=IDLE, o_valid=0, o_result=0, internal counter and shift register cleared. o_ready=1 after reset.
- States: IDLE, SHIFT, DONE.
- o_ready = (state==IDLE) | (state==DONE & i_ready). Combinational from state and i_ready only; never from i_valid.
- Accept occurs when i_valid & o_ready & ~i_flush. Operands and op are captured on the accepting edge.
- Op decode ({i_alt, i_op}):
  - 0000 ADD, 1000 SUB.
  - 0001 SLL.
  - 0010 SLT (signed), 0011 SLTU. Result is 0 or 1, zero-extended.
  - 0100 XOR, 0110 OR, 0111 AND.
  - 0101 SRL, 1101 SRA.
  - Any other alt=1 combination gives result 0 and is single-cycle.
- Arithmetic is modulo 2^XLEN. No carry or overflow output.
- Non-shift op, or shift with shamt=0: result is written to o_result on the accept edge. Next state is DONE, so latency is 1 cycle.
- Shift with shamt N>0: on accept, load A into the shift register, set count=N, go to SHIFT.
  - Each SHIFT cycle shifts by 1 bit (SRA replicates the MSB) and decrements count.
  - On the edge where count goes 1->0, o_result takes the final value and state goes to DONE.
  - Total latency from accept edge to o_valid is N+1 cycles.
  - o_ready=0 throughout SHIFT.
- o_valid = (state==DONE).
- In DONE, o_result is held stable until i_ready.
  - On i_ready with no accept: state goes to IDLE.
  - On i_ready with a new accept: handle the new op as from IDLE, giving back-to-back throughput of 1 op/cycle for non-shift ops.
- i_flush has priority over everything except reset. On the next edge: state=IDLE, o_valid=0, any in-flight shift is discarded, no accept. o_result keeps its last value (don't-care).
- A low pulse on i_rst_n during SHIFT aborts immediately with the same outputs as power-on reset.

Optional Feature:
ALU_BARREL_SHIFT_EN
- Defined: shifts use a single-cycle barrel shifter. Every op has latency 1, SHIFT state and counter are not built, and o_busy is tied 0.
- Undefined: iterative shifter as described above.

Test Plan:
- ADD, A=0xFFFFFFFF, B=0x00000001, i_ready=1 -> o_valid one cycle after accept, o_result=0x00000000.
- SUB (alt=1, op=000), A=5, B=7 -> o_result=0xFFFFFFFE. SLT A=0xFFFFFFFE, B=1 -> 1; SLTU with the same operands -> 0.
- SRA, A=0x80000000, B=3 -> o_busy high 3 cycles, o_ready low, o_valid 4 cycles after accept, o_result=0xF0000000. Under ALU_BARREL_SHIFT_EN, latency is 1.
- SLL with B=0x20 (shamt=0), A=0x12345678 -> latency 1, o_result=0x12345678.
- Backpressure: hold i_ready=0 for 5 cycles after a valid OR result -> o_valid stays 1, o_result stable, o_ready=0. Then i_ready=1 with a new i_valid -> new result the next cycle (back-to-back).
- i_flush asserted 2 cycles into an SRL with shamt=10 -> next cycle state IDLE, o_valid=0, o_ready=1. An i_rst_n pulse mid-shift gives o_valid=0 and o_result=0 immediately.
